// File: rtl/iob_axistream_arb_pkg.sv
// Shared definitions for the packet-level AXI-Stream output arbiter:
// FSM state encoding and round-robin pointer sizing.
package iob_axistream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int MAX_PORTS    = 8;
  localparam int RR_PTR_W_MAX = $clog2(MAX_PORTS);

  // rr_ptr width for a given port count, $clog2(n_ports) but never zero
  function automatic int rr_ptr_w(input int n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_sel.sv
// Combinational round-robin selector: picks the first requester found
// scanning upward from rr_ptr with wrap-around.
module iob_rr_sel
  import iob_axistream_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = rr_ptr_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic               valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_PORTS)) sum = sum - (PTR_W+1)'(N_PORTS);
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_axistream_out_arb.sv
// Packet-level round-robin arbiter sharing one registered AXI-Stream output
// between N_PORTS sources; grants are held from first beat to tlast.
module iob_axistream_out_arb
  import iob_axistream_arb_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int DATA_W      = 8,
  parameter int MAX_PKT_LEN = 1024,
  parameter int LEN_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS*DATA_W-1:0] s_tdata,
  input  logic [N_PORTS-1:0]        s_tvalid,
  input  logic [N_PORTS-1:0]        s_tlast,
  output logic [N_PORTS-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [N_PORTS-1:0]        grant,
  output logic                      busy,
  output logic                      trunc
);

  localparam int               PTR_W    = rr_ptr_w(N_PORTS);
  localparam bit               LIMIT_EN = (MAX_PKT_LEN != 0);
  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(LIMIT_EN ? MAX_PKT_LEN - 1 : 0);

  arb_state_t         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, g_idx;
  logic [LEN_W-1:0]   beat_cnt;
  logic [N_PORTS-1:0] sel_gnt;
  logic               sel_valid;
  logic [DATA_W-1:0]  g_data;
  logic               g_last, g_valid;
  logic               slot_free, accept, out_last;

  iob_rr_sel #(
    .N_PORTS(N_PORTS),
    .PTR_W  (PTR_W)
  ) u_sel (
    .req   (s_tvalid),
    .rr_ptr(rr_ptr),
    .gnt   (sel_gnt),
    .valid (sel_valid)
  );

  always_comb begin
    g_data  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    g_idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        g_data  = s_tdata[i*DATA_W +: DATA_W];
        g_last  = s_tlast[i];
        g_valid = s_tvalid[i];
        g_idx   = PTR_W'(i);
      end
    end
  end

  // The output slot can take a beat when empty or draining this cycle
  assign slot_free = ~m_tvalid | m_tready;
  assign s_tready  = (state == XFER && slot_free) ? grant : '0;
  assign accept    = (state == XFER) && g_valid && slot_free;
  assign out_last  = g_last | (LIMIT_EN && beat_cnt == LAST_CNT);
  assign busy      = (state == XFER) | m_tvalid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_valid) state_nxt = XFER;
      XFER:    if (accept && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      trunc    <= 1'b0;
    end else begin
      state <= state_nxt;
      trunc <= accept & out_last & ~g_last;
      if (state == IDLE && sel_valid) begin
        grant    <= sel_gnt;
        beat_cnt <= '0;
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        m_tdata  <= g_data;
        m_tvalid <= 1'b1;
        m_tlast  <= out_last;
        // Packet end (natural or forced) releases the grant and advances priority
        if (out_last) begin
          grant  <= '0;
          rr_ptr <= (g_idx == PTR_W'(N_PORTS - 1)) ? '0 : g_idx + 1'b1;
        end
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iob_axistream_out_arb.sv
// Directed bench for iob_axistream_out_arb: a 2-port instance with an
// 4-beat packet limit and a 3-port instance with the limit disabled.
module tb_iob_axistream_out_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] a_s_tdata;
  logic [1:0]  a_s_tvalid, a_s_tlast, a_s_tready, a_grant;
  logic [7:0]  a_m_tdata;
  logic        a_m_tvalid, a_m_tlast, a_m_tready, a_busy, a_trunc;

  logic [23:0] b_s_tdata;
  logic [2:0]  b_s_tvalid, b_s_tlast, b_s_tready, b_grant;
  logic [7:0]  b_m_tdata;
  logic        b_m_tvalid, b_m_tlast, b_m_tready, b_busy, b_trunc;

  iob_axistream_out_arb #(.N_PORTS(2), .DATA_W(8), .MAX_PKT_LEN(4), .LEN_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tlast(a_s_tlast), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast), .m_tready(a_m_tready),
    .grant(a_grant), .busy(a_busy), .trunc(a_trunc)
  );

  iob_axistream_out_arb #(.N_PORTS(3), .DATA_W(8), .MAX_PKT_LEN(0), .LEN_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tlast(b_s_tlast), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast), .m_tready(b_m_tready),
    .grant(b_grant), .busy(b_busy), .trunc(b_trunc)
  );

  int vectors = 0;
  int miscompares = 0;
  bit use_b = 1'b0;

  logic [8:0] q0[$], q1[$], q2[$];
  logic       rst_q[$], rdy_q[$];

  logic [2:0] cyc_grant[$], cyc_sready[$];
  logic [7:0] cyc_data[$];
  logic       cyc_valid[$], cyc_last[$], cyc_trunc[$], cyc_busy[$];
  logic [7:0] out_data[$];
  logic       out_last[$];
  int         out_cyc[$];

  task automatic push_pkt(input int port, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [8:0] b;
      b = {(i == n - 1), first + 8'(i)};
      case (port)
        0: q0.push_back(b);
        1: q1.push_back(b);
        default: q2.push_back(b);
      endcase
    end
  endtask

  task automatic present();
    logic [8:0] h;
    a_s_tvalid = '0; a_s_tlast = '0; a_s_tdata = '0;
    b_s_tvalid = '0; b_s_tlast = '0; b_s_tdata = '0;
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
      if (sz != 0) begin
        h = (i == 0) ? q0[0] : (i == 1) ? q1[0] : q2[0];
        if (use_b) begin
          b_s_tvalid[i] = 1'b1;
          b_s_tlast[i]  = h[8];
          b_s_tdata[i*8 +: 8] = h[7:0];
        end else if (i < 2) begin
          a_s_tvalid[i] = 1'b1;
          a_s_tlast[i]  = h[8];
          a_s_tdata[i*8 +: 8] = h[7:0];
        end
      end
    end
  endtask

  task automatic clear_logs();
    cyc_grant.delete(); cyc_sready.delete(); cyc_data.delete(); cyc_valid.delete();
    cyc_last.delete(); cyc_trunc.delete(); cyc_busy.delete();
    out_data.delete(); out_last.delete(); out_cyc.delete();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); q2.delete(); rst_q.delete(); rdy_q.delete();
    rst = 1'b0; a_m_tready = 1'b1; b_m_tready = 1'b1;
    present();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One loop iteration per clock: sample at negedge, advance sources after posedge
  task automatic run_cycles(input int n);
    logic [2:0] vld, rdy, hs;
    logic mv, mr;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      vld = use_b ? b_s_tvalid : {1'b0, a_s_tvalid};
      rdy = use_b ? b_s_tready : {1'b0, a_s_tready};
      hs  = vld & rdy;
      mv  = use_b ? b_m_tvalid : a_m_tvalid;
      mr  = use_b ? b_m_tready : a_m_tready;
      cyc_grant.push_back(use_b ? b_grant : {1'b0, a_grant});
      cyc_sready.push_back(rdy);
      cyc_data.push_back(use_b ? b_m_tdata : a_m_tdata);
      cyc_valid.push_back(mv);
      cyc_last.push_back(use_b ? b_m_tlast : a_m_tlast);
      cyc_trunc.push_back(use_b ? b_trunc : a_trunc);
      cyc_busy.push_back(use_b ? b_busy : a_busy);
      if (mv && mr) begin
        out_data.push_back(use_b ? b_m_tdata : a_m_tdata);
        out_last.push_back(use_b ? b_m_tlast : a_m_tlast);
        out_cyc.push_back(cyc_grant.size() - 1);
      end
      @(posedge clk);
      #1;
      if (hs[0]) void'(q0.pop_front());
      if (hs[1]) void'(q1.pop_front());
      if (hs[2]) void'(q2.pop_front());
      rst = (rst_q.size() != 0) ? rst_q.pop_front() : 1'b1;
      a_m_tready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
      b_m_tready = a_m_tready;
      present();
    end
  endtask

  task automatic test_reset();
    q0.delete(); q1.delete(); q2.delete();
    rst = 1'b0; a_m_tready = 1'b1; b_m_tready = 1'b1;
    push_pkt(0, 8'hAA, 1);
    present();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (a_m_tvalid !== 1'b0 || a_m_tdata !== 8'h00 || a_m_tlast !== 1'b0 || a_trunc !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out: got valid=%b data=%h last=%b trunc=%b expected 0 00 0 0",
               a_m_tvalid, a_m_tdata, a_m_tlast, a_trunc);
    end
    vectors++;
    if (a_grant !== 2'b00 || a_s_tready !== 2'b00 || a_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got grant=%b s_tready=%b busy=%b expected 00 00 0",
               a_grant, a_s_tready, a_busy);
    end
    vectors++;
    if (b_grant !== 3'b000 || b_m_tvalid !== 1'b0 || b_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_b: got grant=%b valid=%b busy=%b expected 000 0 0",
               b_grant, b_m_tvalid, b_busy);
    end
    q0.delete();
    present();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single_source();
    logic [7:0] ed [4] = '{8'h11, 8'h12, 8'h13, 8'h14};
    logic       el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         ec [4] = '{2, 3, 4, 5};
    logic [2:0] eg [7] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
    do_reset(); clear_logs();
    push_pkt(0, 8'h11, 4);
    present();
    run_cycles(7);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (cyc_grant[i] !== eg[i]) begin
        miscompares++;
        $display("[TB] FAIL single_grant c%0d: got %b expected %b", i, cyc_grant[i], eg[i]);
      end
    end
    vectors++;
    if (out_data.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL single_count: got %0d beats expected 4", out_data.size());
    end
    for (int i = 0; i < 4 && i < out_data.size(); i++) begin
      vectors++;
      if (out_data[i] !== ed[i] || out_last[i] !== el[i] || out_cyc[i] != ec[i]) begin
        miscompares++;
        $display("[TB] FAIL single_beat%0d: got %h/%b@c%0d expected %h/%b@c%0d",
                 i, out_data[i], out_last[i], out_cyc[i], ed[i], el[i], ec[i]);
      end
    end
    vectors++;
    if (cyc_busy[5] !== 1'b1 || cyc_busy[6] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_busy: got c5=%b c6=%b expected 1 0", cyc_busy[5], cyc_busy[6]);
    end
    vectors++;
    if (cyc_trunc.sum() with (int'(item)) != 0) begin
      miscompares++;
      $display("[TB] FAIL single_trunc: got pulses expected none");
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg [13] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0};
    logic [7:0] ed [8] = '{8'h21, 8'h22, 8'h31, 8'h32, 8'h23, 8'h24, 8'h33, 8'h34};
    int         ec [8] = '{2, 3, 5, 6, 8, 9, 11, 12};
    do_reset(); clear_logs();
    push_pkt(0, 8'h21, 2); push_pkt(0, 8'h23, 2);
    push_pkt(1, 8'h31, 2); push_pkt(1, 8'h33, 2);
    present();
    run_cycles(13);
    for (int i = 0; i < 13; i++) begin
      vectors++;
      if (cyc_grant[i] !== eg[i]) begin
        miscompares++;
        $display("[TB] FAIL rr_grant c%0d: got %b expected %b", i, cyc_grant[i], eg[i]);
      end
    end
    vectors++;
    if (out_data.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL rr_count: got %0d beats expected 8", out_data.size());
    end
    for (int i = 0; i < 8 && i < out_data.size(); i++) begin
      vectors++;
      if (out_data[i] !== ed[i] || out_last[i] !== (i % 2 == 1) || out_cyc[i] != ec[i]) begin
        miscompares++;
        $display("[TB] FAIL rr_beat%0d: got %h/%b@c%0d expected %h/%b@c%0d",
                 i, out_data[i], out_last[i], out_cyc[i], ed[i], (i % 2 == 1), ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    int         ec [4] = '{5, 6, 7, 8};
    do_reset(); clear_logs();
    push_pkt(0, 8'h41, 4);
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b0};
    present();
    run_cycles(10);
    for (int i = 2; i <= 4; i++) begin
      vectors++;
      if (cyc_sready[i] !== 3'b000 || cyc_data[i] !== 8'h41 || cyc_valid[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold c%0d: got s_tready=%b data=%h valid=%b expected 000 41 1",
                 i, cyc_sready[i], cyc_data[i], cyc_valid[i]);
      end
    end
    vectors++;
    if (out_data.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d beats expected 4", out_data.size());
    end
    for (int i = 0; i < 4 && i < out_data.size(); i++) begin
      vectors++;
      if (out_data[i] !== ed[i] || out_last[i] !== (i == 3) || out_cyc[i] != ec[i]) begin
        miscompares++;
        $display("[TB] FAIL bp_beat%0d: got %h/%b@c%0d expected %h/%b@c%0d",
                 i, out_data[i], out_last[i], out_cyc[i], ed[i], (i == 3), ec[i]);
      end
    end
  endtask

  task automatic test_truncation();
    logic [2:0] eg [15] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2,
                            3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0};
    logic [7:0] ed [10] = '{8'h61, 8'h62, 8'h51, 8'h52, 8'h53, 8'h54, 8'h63, 8'h64, 8'h55, 8'h56};
    logic       el [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int         ec [10] = '{2, 3, 5, 6, 7, 8, 10, 11, 13, 14};
    do_reset(); clear_logs();
    push_pkt(0, 8'h61, 2); push_pkt(0, 8'h63, 2);
    push_pkt(1, 8'h51, 6);
    present();
    run_cycles(15);
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if (cyc_grant[i] !== eg[i] || cyc_trunc[i] !== (i == 8)) begin
        miscompares++;
        $display("[TB] FAIL trunc_cycle c%0d: got grant=%b trunc=%b expected %b %b",
                 i, cyc_grant[i], cyc_trunc[i], eg[i], (i == 8));
      end
    end
    vectors++;
    if (out_data.size() != 10) begin
      miscompares++;
      $display("[TB] FAIL trunc_count: got %0d beats expected 10", out_data.size());
    end
    for (int i = 0; i < 10 && i < out_data.size(); i++) begin
      vectors++;
      if (out_data[i] !== ed[i] || out_last[i] !== el[i] || out_cyc[i] != ec[i]) begin
        miscompares++;
        $display("[TB] FAIL trunc_beat%0d: got %h/%b@c%0d expected %h/%b@c%0d",
                 i, out_data[i], out_last[i], out_cyc[i], ed[i], el[i], ec[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] ed [4] = '{8'h90, 8'h81, 8'h91, 8'h83};
    logic       el [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int         ec [4] = '{2, 4, 7, 9};
    do_reset(); clear_logs();
    push_pkt(0, 8'h90, 1);
    push_pkt(1, 8'h81, 3);
    rst_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    present();
    run_cycles(5);
    push_pkt(0, 8'h91, 1);
    present();
    run_cycles(6);
    vectors++;
    if (cyc_valid[5] !== 1'b0 || cyc_data[5] !== 8'h00 || cyc_last[5] !== 1'b0 ||
        cyc_grant[5] !== 3'b000 || cyc_sready[5] !== 3'b000 || cyc_busy[5] !== 1'b0 ||
        cyc_trunc[5] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_values: got valid=%b data=%h last=%b grant=%b s_tready=%b busy=%b trunc=%b expected all zero",
               cyc_valid[5], cyc_data[5], cyc_last[5], cyc_grant[5], cyc_sready[5], cyc_busy[5], cyc_trunc[5]);
    end
    vectors++;
    if (cyc_grant[6] !== 3'b001 || cyc_grant[8] !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL midrst_restart: got c6=%b c8=%b expected 001 010", cyc_grant[6], cyc_grant[8]);
    end
    vectors++;
    if (out_data.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL midrst_count: got %0d beats expected 4", out_data.size());
    end
    for (int i = 0; i < 4 && i < out_data.size(); i++) begin
      vectors++;
      if (out_data[i] !== ed[i] || out_last[i] !== el[i] || out_cyc[i] != ec[i]) begin
        miscompares++;
        $display("[TB] FAIL midrst_beat%0d: got %h/%b@c%0d expected %h/%b@c%0d",
                 i, out_data[i], out_last[i], out_cyc[i], ed[i], el[i], ec[i]);
      end
    end
  endtask

  task automatic test_three_port();
    logic [2:0] eg [10] = '{3'd0, 3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd0};
    int         ec [6] = '{2, 3, 5, 6, 8, 9};
    use_b = 1'b1;
    do_reset(); clear_logs();
    push_pkt(2, 8'hC1, 2); push_pkt(2, 8'hC3, 2); push_pkt(2, 8'hC5, 2);
    present();
    run_cycles(10);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (cyc_grant[i] !== eg[i]) begin
        miscompares++;
        $display("[TB] FAIL p3_grant c%0d: got %b expected %b", i, cyc_grant[i], eg[i]);
      end
    end
    vectors++;
    if (out_data.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL p3_count: got %0d beats expected 6", out_data.size());
    end
    for (int i = 0; i < 6 && i < out_data.size(); i++) begin
      vectors++;
      if (out_data[i] !== 8'hC1 + 8'(i) || out_last[i] !== (i % 2 == 1) || out_cyc[i] != ec[i]) begin
        miscompares++;
        $display("[TB] FAIL p3_beat%0d: got %h/%b@c%0d expected %h/%b@c%0d",
                 i, out_data[i], out_last[i], out_cyc[i], 8'hC1 + 8'(i), (i % 2 == 1), ec[i]);
      end
    end
    use_b = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    a_m_tready = 1'b1;
    b_m_tready = 1'b1;
    present();
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_mid_packet();
    test_three_port();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_axistream_out_arb.md
# iob_axistream_out_arb

Packet-level round-robin arbiter that shares one byte-wide AXI-Stream output, normally the write side of the AXI-Stream output FIFO, between N_PORTS independent byte-stream sources. A grant is held from a packet's first beat until its tlast beat, so packets from different sources are never interleaved. Each packet is also bounded by a maximum length. The output passes through one registered stage, so m_tdata/m_tvalid/m_tlast are flop outputs.

## Interface
- N_PORTS, 2: number of requesting sources (2..8).
- DATA_W, 8: beat width; must match the downstream stream width.
- MAX_PKT_LEN, 1024: beats per packet before forced termination; 0 disables the limit.
- LEN_W, 16: width of the beat counter; MAX_PKT_LEN < 2^LEN_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset); sampled on clk only.
- s_tdata  in  N_PORTS*DATA_W  source data; port i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  N_PORTS  per-source valid.
- s_tlast  in  N_PORTS  per-source end of packet.
- s_tready  out  N_PORTS  per-source ready.
- m_tdata  out  DATA_W  output data.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of packet; includes forced terminations.
- m_tready  in  1  downstream ready.
- grant  out  N_PORTS  one-hot current owner; 0 when idle.
- busy  out  1  1 while in XFER or while the output register holds a beat.
- trunc  out  1  one-cycle pulse when a packet is force-terminated at MAX_PKT_LEN.

## Operation
- FSM states:
  - IDLE: grant=0. If any s_tvalid is high, select the first requesting port found scanning from rr_ptr upward with wrap-around. Load grant, clear beat_cnt, go to XFER.
  - XFER: only the granted port is served.
    - s_tready[g] = (~m_tvalid | m_tready); all other s_tready are 0.
    - An accepted beat (s_tvalid[g] & s_tready[g]) loads the output register. m_tlast = s_tlast[g] | (MAX_PKT_LEN != 0 & beat_cnt == MAX_PKT_LEN-1). beat_cnt increments.
    - An accepted beat with m_tlast set returns the FSM to IDLE and sets rr_ptr = (g+1) mod N_PORTS.
    - If that beat's source tlast was 0, trunc pulses. The source's remaining beats form a new packet that is arbitrated normally.
- Output register: m_tvalid clears on m_tready when no new beat is loaded in the same cycle. A simultaneous load and drain keeps m_tvalid=1, giving full throughput of one beat per cycle.
- Source deasserting s_tvalid mid-packet: the grant is held indefinitely; there is no timeout.
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, grant=0, s_tready=0, trunc=0, busy=0, rr_ptr=0, beat_cnt=0, state=IDLE.
- Reset mid-packet: the held beat is discarded and the partial packet is lost. No tlast is emitted; recovery is the system's responsibility.

## Timing
- Arbitration: a request seen in IDLE at cycle t gives grant at t+1. The first s_tready is high at t+1, so the first beat can be accepted at t+1.
- Data latency: a beat accepted at cycle t appears on m_t* at t+1.
- Packet gap: one IDLE cycle between packets. A packet of L beats occupies L+1 arbitration cycles when downstream does not stall.
- Output handshake: m_tdata and m_tlast are stable while m_tvalid & ~m_tready, per AXI-Stream rules.
- trunc is asserted in the cycle after the truncating beat is accepted, aligned with that beat on m_t*.
- Single-beat packet (tlast on the first beat) is legal and returns to IDLE after one XFER cycle.

## Structure
- Shared package iob_axistream_arb_pkg holds:
  - the state encoding (IDLE=1'b0, XFER=1'b1);
  - a localparam for the rr_ptr width, $clog2(N_PORTS).
- Sub-module iob_rr_sel (combinational): takes req[N_PORTS] and rr_ptr, returns a one-hot grant and a valid flag.
- Everything else (FSM, beat counter, output register) is in the top module.

## Test plan
- Single source, port 0: 4-beat packet 0x11..0x14 with tlast on 0x14, m_tready=1. Expected: grant=01 one cycle after request, m_tdata 0x11..0x14 on consecutive cycles, m_tlast only with 0x14, then IDLE.
- Round-robin with both ports always requesting 2-beat packets: grant sequence 01,10,01,10. No interleaving within a packet. One idle cycle between packets.
- Backpressure: hold m_tready=0 for 3 cycles mid-packet. Expected: m_tdata frozen, s_tready[g]=0 while the output register is full, no beat lost or duplicated.
- Truncation with MAX_PKT_LEN=4 and a 6-beat packet on port 1. Expected:
  - m_tlast on beat 4, trunc pulses once;
  - beats 5-6 appear as a separate 2-beat packet;
  - if port 0 is requesting, its packet is served in between.
- Reset: assert rst=0 during beat 2 of a packet. Expected: next cycle all outputs at reset values. After rst=1, arbitration restarts from port 0.
- N_PORTS=3 with only port 2 requesting: grant=100 each packet, with no dead cycles beyond the single IDLE gap.
